regfile_decode_bank: RTL and testbench
======================================

// Module: regfile_decode_bank
// PURPOSE
//   Parametrised register file: NREGS x WIDTH storage, two read ports, one write port.
//   Successor to the fixed 4:16 read wordline decoder: the read and write one-hot wordline
//   decoders are built in, sized by NREGS, with write-through bypass and optional registered reads.
//   Sits in the decode stage of the CPU pipeline; feeds the ID/EX operand latches.
// PARAMETERS
//   NREGS     16  number of registers; any value 2..64; ID width AW = $clog2(NREGS)
//   WIDTH     16  bits per register
//   ZERO_REG  1   1: register 0 reads as 0 and ignores writes; 0: register 0 is ordinary
//   BYPASS    1   1: same-cycle write data forwarded to a matching read; 0: no forwarding
//   READ_REG  0   0: combinational read (0 latency); 1: registered read (1-cycle latency)
// PORTS
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   WriteReg   in   1      write enable
//   DstReg     in   AW     write register ID
//   DstData    in   WIDTH  write data
//   SrcReg1    in   AW     read port 1 register ID
//   SrcReg2    in   AW     read port 2 register ID
//   RdEn       in   1      read enable; used only when READ_REG=1
//   SrcData1   out  WIDTH  read port 1 data
//   SrcData2   out  WIDTH  read port 2 data
//   RdValid    out  1      READ_REG=1: RdEn delayed one cycle; READ_REG=0: tied to 1
//   WrWordline out  NREGS  one-hot decoded write select actually applied this cycle (0 if none)
// BEHAVIOUR
//   - Reset (rst_n=0, async): all registers = 0; SrcData1/2 output regs = 0; RdValid = 0.
//     Reset asserted mid-write: the write is lost; storage reads 0 after release.
//   - Decode: wordline[i] = (ID == i); IDs >= NREGS decode to all-zero wordlines.
//   - Write: at posedge clk, reg[DstReg] <= DstData when WriteReg=1 and WrWordline != 0.
//     WrWordline = 0 when WriteReg=0, DstReg >= NREGS, or (ZERO_REG=1 and DstReg=0).
//   - Read value (per port, p = 1,2), computed combinationally:
//       ID >= NREGS                       -> 0
//       ZERO_REG=1 and ID = 0             -> 0 (never bypassed)
//       BYPASS=1 and WrWordline[ID]=1     -> DstData (write-through)
//       otherwise                         -> reg[ID] (pre-edge contents)
//   - READ_REG=0: SrcDataP = read value, same cycle; RdEn ignored; RdValid = 1 outside reset
//     (RdValid = 0 while rst_n = 0).
//   - READ_REG=1: at posedge, if RdEn=1, SrcDataP <= read value (including bypass); if RdEn=0
//     SrcDataP holds; RdValid <= RdEn. Latency exactly 1 cycle.
//   - Both read ports may address the same register, incl. the one being written; both see
//     identical values.
//   - BYPASS=0, read and write same ID same cycle: read returns old value; new value visible
//     the following cycle (READ_REG=0) or on the following capture (READ_REG=1).
//   - No internal state other than storage and read output registers; no X on any output
//     after reset for any input sequence with known inputs.
// TESTING
//   1. Reset: write R3=0xBEEF, pulse rst_n low mid-cycle -> R3 reads 0x0000, RdValid=0 immediately.
//   2. Write/read: write R5=0x1234, next cycle SrcReg1=5 -> SrcData1=0x1234; WrWordline=0x0020
//      during the write cycle (NREGS=16).
//   3. Zero reg (ZERO_REG=1): WriteReg=1, DstReg=0, DstData=0xFFFF -> WrWordline=0, SrcReg1=0
//      reads 0x0000 same and next cycle.
//   4. Bypass: R7=0x1111, same cycle write R7=0x2222 with SrcReg1=SrcReg2=7 -> BYPASS=1:
//      both 0x2222; BYPASS=0: both 0x1111, then 0x2222 next cycle.
//   5. READ_REG=1: RdEn=1, SrcReg2=9 (R9=0xA5A5) -> SrcData2=0xA5A5, RdValid=1 one cycle later;
//      RdEn=0 next -> SrcData2 holds, RdValid=0.
//   6. NREGS=12: DstReg=13 write 0xCAFE -> WrWordline=0, no register changes; SrcReg1=13 -> 0.

Source files
------------

// File: rtl/regfile_decode_bank.sv
// Decode-stage register file: NREGS x WIDTH storage, two read ports, one write port.
// The one-hot write/read wordline decoders are internal and sized by NREGS.
// Optional write-through bypass, hardwired zero register and registered read outputs.
module regfile_decode_bank #(
    parameter int NREGS    = 16,
    parameter int WIDTH    = 16,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0,
    localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             WriteReg,
    input  logic [AW-1:0]    DstReg,
    input  logic [WIDTH-1:0] DstData,
    input  logic [AW-1:0]    SrcReg1,
    input  logic [AW-1:0]    SrcReg2,
    input  logic             RdEn,
    output logic [WIDTH-1:0] SrcData1,
    output logic [WIDTH-1:0] SrcData2,
    output logic             RdValid,
    output logic [NREGS-1:0] WrWordline
);

    logic [WIDTH-1:0] r_mem [NREGS];
    logic [NREGS-1:0] w_wr_wordline;
    logic [WIDTH-1:0] w_cell [NREGS];
    logic [WIDTH-1:0] w_rd_val1;
    logic [WIDTH-1:0] w_rd_val2;

    // Write wordline decode: one-hot, dropped when disabled or aimed at the hardwired zero register.
    // IDs >= NREGS never match any loop index, so they decode to an all-zero wordline.
    always_comb begin
        w_wr_wordline = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_wr_wordline[i] = WriteReg && (DstReg == AW'(i)) && !((ZERO_REG != 0) && (i == 0));
        end
    end

    assign WrWordline = w_wr_wordline;

    // Per-register visible value: zero register, then write-through, then pre-edge contents
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            w_cell[i] = ((ZERO_REG != 0) && (i == 0))            ? {WIDTH{1'b0}} :
                        ((BYPASS != 0) && w_wr_wordline[i])       ? DstData       :
                                                                    r_mem[i];
        end
    end

    // Read wordline mux: AND-OR select per port; unmatched (out-of-range) IDs read as zero
    always_comb begin
        w_rd_val1 = '0;
        w_rd_val2 = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_rd_val1 = w_rd_val1 | ((SrcReg1 == AW'(i)) ? w_cell[i] : {WIDTH{1'b0}});
            w_rd_val2 = w_rd_val2 | ((SrcReg2 == AW'(i)) ? w_cell[i] : {WIDTH{1'b0}});
        end
    end

    // Storage array: cleared asynchronously, written through the decoded wordline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_wr_wordline[i]) begin
                    r_mem[i] <= DstData;
                end else begin
                    r_mem[i] <= r_mem[i];
                end
            end
        end
    end

    generate
        if (READ_REG != 0) begin : g_rd_reg
            logic [WIDTH-1:0] r_src_data1;
            logic [WIDTH-1:0] r_src_data2;
            logic             r_rd_valid;

            // Registered read: capture both ports on RdEn, otherwise hold; valid tracks RdEn
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_src_data1 <= '0;
                    r_src_data2 <= '0;
                    r_rd_valid  <= 1'b0;
                end else begin
                    r_rd_valid <= RdEn;
                    if (RdEn) begin
                        r_src_data1 <= w_rd_val1;
                        r_src_data2 <= w_rd_val2;
                    end else begin
                        r_src_data1 <= r_src_data1;
                        r_src_data2 <= r_src_data2;
                    end
                end
            end

            assign SrcData1 = r_src_data1;
            assign SrcData2 = r_src_data2;
            assign RdValid  = r_rd_valid;
        end else begin : g_rd_comb
            // Zero-latency read: RdEn has no effect, data is valid whenever reset is released
            logic w_rden_unused;
            assign w_rden_unused = RdEn;
            assign SrcData1      = w_rd_val1;
            assign SrcData2      = w_rd_val2;
            assign RdValid       = rst_n;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_decode_bank.sv
// Bench for regfile_decode_bank: two configurations share one stimulus stream.
//   A: NREGS=16, ZERO_REG=1, BYPASS=1, READ_REG=0
//   B: NREGS=12, ZERO_REG=0, BYPASS=0, READ_REG=1
// Expected values come from a register-array model built from the read/write rules.
module tb_regfile_decode_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        WriteReg;
    logic [3:0]  DstReg;
    logic [15:0] DstData;
    logic [3:0]  SrcReg1;
    logic [3:0]  SrcReg2;
    logic        RdEn;

    logic [15:0] a_d1, a_d2, b_d1, b_d2;
    logic        a_v, b_v;
    logic [15:0] a_wl;
    logic [11:0] b_wl;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] mem_a [16];
    logic [15:0] mem_b [12];
    logic [15:0] exp_b1, exp_b2;
    logic        exp_bv;

    always #5 clk = ~clk;

    regfile_decode_bank #(.NREGS(16), .WIDTH(16), .ZERO_REG(1), .BYPASS(1), .READ_REG(0)) u_a (
        .clk(clk), .rst_n(rst_n), .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
        .SrcReg1(SrcReg1), .SrcReg2(SrcReg2), .RdEn(RdEn),
        .SrcData1(a_d1), .SrcData2(a_d2), .RdValid(a_v), .WrWordline(a_wl));

    regfile_decode_bank #(.NREGS(12), .WIDTH(16), .ZERO_REG(0), .BYPASS(0), .READ_REG(1)) u_b (
        .clk(clk), .rst_n(rst_n), .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
        .SrcReg1(SrcReg1), .SrcReg2(SrcReg2), .RdEn(RdEn),
        .SrcData1(b_d1), .SrcData2(b_d2), .RdValid(b_v), .WrWordline(b_wl));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Config A read: reg 0 is zero, a same-cycle write to the addressed reg is forwarded
    function automatic logic [15:0] ref_a(input int id);
        if (id == 0) return 16'h0000;
        if (WriteReg && (int'(DstReg) == id)) return DstData;
        return mem_a[id];
    endfunction

    // Config B read: no forwarding, IDs beyond 11 read as zero
    function automatic logic [15:0] ref_b(input int id);
        if (id >= 12) return 16'h0000;
        return mem_b[id];
    endfunction

    function automatic logic [15:0] ref_wl_a();
        if (WriteReg && (DstReg != 4'd0)) return 16'(1 << DstReg);
        return 16'h0000;
    endfunction

    function automatic logic [15:0] ref_wl_b();
        if (WriteReg && (int'(DstReg) < 12)) return 16'(1 << DstReg);
        return 16'h0000;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mem_a[i] = 16'h0000;
        for (int i = 0; i < 12; i++) mem_b[i] = 16'h0000;
        exp_b1 = 16'h0000;
        exp_b2 = 16'h0000;
        exp_bv = 1'b0;
    endtask

    task automatic drive(input logic we, input logic [3:0] dst, input logic [15:0] dd,
                         input logic [3:0] s1, input logic [3:0] s2, input logic re);
        WriteReg = we;
        DstReg   = dst;
        DstData  = dd;
        SrcReg1  = s1;
        SrcReg2  = s2;
        RdEn     = re;
    endtask

    // Called a few ns after a negedge with inputs applied: check, clock once, advance model.
    task automatic check_tick();
        logic [15:0] nb1, nb2;
        #1;
        chk("a_rd1",   a_d1, ref_a(int'(SrcReg1)));
        chk("a_rd2",   a_d2, ref_a(int'(SrcReg2)));
        chk("a_wl",    a_wl, ref_wl_a());
        chk("a_valid", 16'(a_v), 16'h0001);
        chk("b_rd1",   b_d1, exp_b1);
        chk("b_rd2",   b_d2, exp_b2);
        chk("b_valid", 16'(b_v), 16'(exp_bv));
        chk("b_wl",    16'(b_wl), ref_wl_b());
        nb1 = RdEn ? ref_b(int'(SrcReg1)) : exp_b1;
        nb2 = RdEn ? ref_b(int'(SrcReg2)) : exp_b2;
        @(posedge clk);
        if (WriteReg && (DstReg != 4'd0)) mem_a[DstReg] = DstData;
        if (WriteReg && (int'(DstReg) < 12)) mem_b[DstReg] = DstData;
        exp_b1 = nb1;
        exp_b2 = nb2;
        exp_bv = RdEn;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 16'h0000, 4'd0, 4'd0, 1'b0);
        model_clear();
        #2;
        chk("rst_a_valid", 16'(a_v), 16'h0000);
        chk("rst_b_valid", 16'(b_v), 16'h0000);
        chk("rst_b_rd1",   b_d1, 16'h0000);
        chk("rst_b_rd2",   b_d2, 16'h0000);
        chk("rst_a_rd1",   a_d1, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // 1. reset mid-cycle wipes storage and drops RdValid at once; the pending write is lost
        drive(1'b1, 4'd3, 16'hBEEF, 4'd3, 4'd3, 1'b1);
        check_tick();
        rst_n = 1'b0;
        drive(1'b1, 4'd4, 16'h5555, 4'd3, 4'd3, 1'b1);
        #1;
        chk("t1_a_valid", 16'(a_v), 16'h0000);
        chk("t1_b_valid", 16'(b_v), 16'h0000);
        chk("t1_a_r3",    a_d1, 16'h0000);
        chk("t1_b_rd1",   b_d1, 16'h0000);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        drive(1'b0, 4'd0, 16'h0000, 4'd3, 4'd4, 1'b1);
        #2;
        chk("t1_r3_after", a_d1, 16'h0000);
        chk("t1_r4_lost",  a_d2, 16'h0000);
        check_tick();

        // 2. write then read back, one-hot wordline during the write
        drive(1'b1, 4'd5, 16'h1234, 4'd0, 4'd0, 1'b0);
        #2;
        chk("t2_wl", a_wl, 16'h0020);
        check_tick();
        drive(1'b0, 4'd0, 16'h0000, 4'd5, 4'd5, 1'b1);
        #2;
        chk("t2_rd", a_d1, 16'h1234);
        check_tick();

        // 3. zero register ignores writes (config A)
        drive(1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0, 1'b0);
        #2;
        chk("t3_wl",  a_wl, 16'h0000);
        chk("t3_rd0", a_d1, 16'h0000);
        check_tick();
        drive(1'b0, 4'd0, 16'h0000, 4'd0, 4'd0, 1'b0);
        #2;
        chk("t3_rd0_next", a_d1, 16'h0000);
        check_tick();

        // 4. bypass on A, old value then new value on B
        drive(1'b1, 4'd7, 16'h1111, 4'd0, 4'd0, 1'b0);
        check_tick();
        drive(1'b1, 4'd7, 16'h2222, 4'd7, 4'd7, 1'b1);
        #2;
        chk("t4_a_rd1", a_d1, 16'h2222);
        chk("t4_a_rd2", a_d2, 16'h2222);
        check_tick();
        drive(1'b0, 4'd0, 16'h0000, 4'd7, 4'd7, 1'b1);
        #2;
        chk("t4_b_old1", b_d1, 16'h1111);
        chk("t4_b_old2", b_d2, 16'h1111);
        check_tick();
        drive(1'b0, 4'd0, 16'h0000, 4'd0, 4'd0, 1'b0);
        #2;
        chk("t4_b_new", b_d1, 16'h2222);
        check_tick();

        // 5. registered read latency and hold on B
        drive(1'b1, 4'd9, 16'hA5A5, 4'd0, 4'd0, 1'b0);
        check_tick();
        drive(1'b0, 4'd0, 16'h0000, 4'd0, 4'd9, 1'b1);
        check_tick();
        drive(1'b0, 4'd0, 16'h0000, 4'd0, 4'd3, 1'b0);
        #2;
        chk("t5_rd2",   b_d2, 16'hA5A5);
        chk("t5_valid", 16'(b_v), 16'h0001);
        check_tick();
        drive(1'b0, 4'd0, 16'h0000, 4'd0, 4'd0, 1'b0);
        #2;
        chk("t5_hold",     b_d2, 16'hA5A5);
        chk("t5_valid_lo", 16'(b_v), 16'h0000);
        check_tick();

        // 6. out-of-range ID on the 12-entry config
        drive(1'b1, 4'd13, 16'hCAFE, 4'd13, 4'd13, 1'b1);
        #2;
        chk("t6_wl", 16'(b_wl), 16'h0000);
        check_tick();
        drive(1'b0, 4'd0, 16'h0000, 4'd13, 4'd0, 1'b0);
        #2;
        chk("t6_rd", b_d1, 16'h0000);
        check_tick();

        // Random traffic, biased so reads often hit the register being written
        for (int n = 0; n < 600; n++) begin
            logic [3:0] d;
            logic [3:0] s1;
            logic [3:0] s2;
            d  = 4'($urandom_range(0, 15));
            s1 = ($urandom_range(0, 3) == 0) ? d : 4'($urandom_range(0, 15));
            s2 = ($urandom_range(0, 3) == 0) ? d : 4'($urandom_range(0, 15));
            drive(1'($urandom_range(0, 1)), d, 16'($urandom), s1, s2, 1'($urandom_range(0, 1)));
            check_tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
